// File: rtl/rv32_mod_bus_responder_ram.sv
// rv32_mod_bus_responder_ram
// Word-organised RAM acting as the responder on the req/ack/err handshake bus.
// One transfer is sampled in IDLE, held for a programmable number of wait
// states, and completed with a single registered ack or err pulse in RESP.
// Writes commit at the edge that closes RESP, so a read issued in the very
// next IDLE cycle already sees the new data.

module rv32_mod_bus_responder_ram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   output logic        ack,
   output logic        err,
   output logic [31:0] data_o
);

   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
   // Window size in bytes, one bit wider so very large depths cannot wrap.
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
   // Counter preload; only meaningful when at least one wait state exists.
   localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [3:0]         wait_cnt;
   logic [3:0]         next_wait_cnt;

   // Transfer captured when IDLE accepts a request.
   logic               lat_wr;
   logic [3:0]         lat_be;
   logic [31:0]        lat_data;
   logic [IDX_W-1:0]   lat_idx;
   logic               lat_bad;

   // Decode of the live bus inputs (only consulted while IDLE).
   logic [31:0]        in_offset;
   logic               in_bad;
   logic [IDX_W-1:0]   in_idx;

   // Attributes of the transfer the next response belongs to.
   logic               sel_wr;
   logic               sel_bad;
   logic [IDX_W-1:0]   sel_idx;

   // Next values of the registered outputs.
   logic               ack_d;
   logic               err_d;
   logic [31:0]        data_o_d;

   logic [31:0]        mem [DEPTH_WORDS];

   // Address decode: offset from the window base, range check and word index.
   always_comb begin
      in_offset = addr - BASE_ADDR;
      in_bad    = ({1'b0, in_offset} >= SPAN_BYTES) || (be == 4'b0000);
      in_idx    = in_offset[IDX_W+1:2];
   end

   // When IDLE accepts a request with no wait states the response is formed
   // from the live inputs; otherwise it comes from the latched transfer.
   always_comb begin
      if (state == ST_IDLE) begin
         sel_wr  = wr;
         sel_bad = in_bad;
         sel_idx = in_idx;
      end else begin
         sel_wr  = lat_wr;
         sel_bad = lat_bad;
         sel_idx = lat_idx;
      end
   end

   // State register and wait counter, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_wait_cnt;
      end
   end

   // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE, counting wait states.
   always_comb begin
      next_state    = state;
      next_wait_cnt = wait_cnt;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (WAIT_STATES > 0) begin
                  next_state    = ST_WAIT;
                  next_wait_cnt = WAIT_LOAD;
               end else begin
                  next_state = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               next_state = ST_RESP;
            end else begin
               next_wait_cnt = wait_cnt - 4'd1;
            end
         end
         ST_RESP: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state    = ST_IDLE;
            next_wait_cnt = 4'd0;
         end
      endcase
   end

   // Output logic: the response pulse and read data are prepared on the
   // cycle before RESP so that they appear registered during RESP only.
   always_comb begin
      ack_d    = 1'b0;
      err_d    = 1'b0;
      data_o_d = 32'h0;
      if (next_state == ST_RESP) begin
         if (sel_bad) begin
            err_d = 1'b1;
         end else begin
            ack_d = 1'b1;
            if (!sel_wr) begin
               data_o_d = mem[sel_idx];
            end
         end
      end
   end

   // Registered response outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ack    <= 1'b0;
         err    <= 1'b0;
         data_o <= 32'h0;
      end else begin
         ack    <= ack_d;
         err    <= err_d;
         data_o <= data_o_d;
      end
   end

   // Capture the transfer when IDLE accepts a request; later bus activity
   // during WAIT or RESP cannot disturb it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lat_wr   <= 1'b0;
         lat_be   <= 4'b0000;
         lat_data <= 32'h0;
         lat_idx  <= '0;
         lat_bad  <= 1'b0;
      end else if (state == ST_IDLE && req) begin
         lat_wr   <= wr;
         lat_be   <= be;
         lat_data <= data_i;
         lat_idx  <= in_idx;
         lat_bad  <= in_bad;
      end
   end

   // Byte-enabled write commit at the edge closing RESP; reset drops it and
   // the storage itself is never cleared.
   always_ff @(posedge clk) begin
      if (reset && state == ST_RESP && lat_wr && !lat_bad) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) begin
               mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_rv32_mod_bus_responder_ram.sv
// tb_rv32_mod_bus_responder_ram
// Three responders with 1, 0 and 3 wait states share one clock. Each driven
// transfer pushes its expected response (kind, data, due cycle) onto a
// scoreboard; a negedge monitor pops and compares whenever a DUT answers.

module tb_rv32_mod_bus_responder_ram;

   localparam int NI = 3;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        rst_a  [NI];
   logic        req_a  [NI];
   logic        wr_a   [NI];
   logic [3:0]  be_a   [NI];
   logic [31:0] addr_a [NI];
   logic [31:0] din_a  [NI];
   logic        ack_a  [NI];
   logic        err_a  [NI];
   logic [31:0] dout_a [NI];

   typedef struct {
      int          k;
      logic        is_err;
      logic [31:0] data;
      int          due;
      string       tag;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mdl [int];

   // Free-running clock and cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   rv32_mod_bus_responder_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut_ws1 (
      .clk(clk), .reset(rst_a[0]), .req(req_a[0]), .wr(wr_a[0]), .be(be_a[0]),
      .addr(addr_a[0]), .data_i(din_a[0]), .ack(ack_a[0]), .err(err_a[0]), .data_o(dout_a[0]));

   rv32_mod_bus_responder_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .reset(rst_a[1]), .req(req_a[1]), .wr(wr_a[1]), .be(be_a[1]),
      .addr(addr_a[1]), .data_i(din_a[1]), .ack(ack_a[1]), .err(err_a[1]), .data_o(dout_a[1]));

   rv32_mod_bus_responder_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_ws3 (
      .clk(clk), .reset(rst_a[2]), .req(req_a[2]), .wr(wr_a[2]), .be(be_a[2]),
      .addr(addr_a[2]), .data_i(din_a[2]), .ack(ack_a[2]), .err(err_a[2]), .data_o(dout_a[2]));

   function automatic int wsOf(input int k);
      return (k == 0) ? 1 : (k == 1) ? 0 : 3;
   endfunction

   function automatic logic [31:0] mergeLanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] lanes);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // Scoreboard monitor: any response is matched against the oldest entry.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (ack_a[k] === 1'b1 || err_a[k] === 1'b1) begin
            if (sb.size() == 0 || sb[0].k != k) begin
               checkOutput($sformatf("unexpected_resp_dut%0d", k), {30'd0, ack_a[k], err_a[k]}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput({e.tag, "_err"},  {31'd0, err_a[k]}, {31'd0, e.is_err});
               checkOutput({e.tag, "_ack"},  {31'd0, ack_a[k]}, {31'd0, !e.is_err});
               checkOutput({e.tag, "_data"}, dout_a[k], e.data);
               checkOutput({e.tag, "_cyc"},  cyc, e.due);
            end
         end
      end
   end

   // Drive one request on instance k and push what the model expects back.
   task automatic applyStimulus(input int k, input string tag, input logic w, input logic [3:0] lanes,
                                input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   key;
      logic bad;
      key = k * 100000 + int'(a >> 2);
      bad = (a >= 32'h1000) || (lanes == 4'b0000);
      e.k = k;
      e.tag = tag;
      e.is_err = bad;
      e.data = 32'h0;
      e.due = cyc + 1 + wsOf(k);
      if (!bad) begin
         if (w) mdl[key] = mergeLanes(mdl.exists(key) ? mdl[key] : 32'h0, d, lanes);
         else e.data = mdl.exists(key) ? mdl[key] : 32'h0;
      end
      sb.push_back(e);
      req_a[k] = 1'b1; wr_a[k] = w; be_a[k] = lanes; addr_a[k] = a; din_a[k] = d;
   endtask

   // Wait (bounded) until every pushed response has been seen.
   task automatic waitDone(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         checkOutput({tag, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic transfer(input int k, input string tag, input logic w, input logic [3:0] lanes,
                           input logic [31:0] a, input logic [31:0] d);
      applyStimulus(k, tag, w, lanes, a, d);
      @(posedge clk); #1;
      req_a[k] = 1'b0;
      waitDone(tag);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_a[k] = 1'b0; req_a[k] = 1'b0; wr_a[k] = 1'b0; be_a[k] = 4'h0;
         addr_a[k] = 32'h0; din_a[k] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         checkOutput($sformatf("reset_ack%0d", k), {31'd0, ack_a[k]}, 32'd0);
         checkOutput($sformatf("reset_err%0d", k), {31'd0, err_a[k]}, 32'd0);
         checkOutput($sformatf("reset_data%0d", k), dout_a[k], 32'd0);
         rst_a[k] = 1'b1;
      end
      @(posedge clk); #1;

      $display("[TB] one wait state: full, byte-lane and error transfers");
      transfer(0, "w0",        1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_F00D);
      transfer(0, "w10",       1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
      transfer(0, "r10",       1'b0, 4'hF, 32'h0000_0010, 32'h0);
      transfer(0, "w20",       1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
      transfer(0, "w20_lane2", 1'b1, 4'b0100, 32'h0000_0020, 32'h00AA_0000);
      transfer(0, "r20",       1'b0, 4'hF, 32'h0000_0020, 32'h0);
      transfer(0, "w20_lane0", 1'b1, 4'b0001, 32'h0000_0022, 32'hFFFF_FF77);
      transfer(0, "r20b",      1'b0, 4'b0010, 32'h0000_0020, 32'h0);
      transfer(0, "r1000_oob", 1'b0, 4'hF, 32'h0000_1000, 32'h0);
      transfer(0, "w1000_oob", 1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF);
      transfer(0, "w10_be0",   1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000);
      transfer(0, "r0_after",  1'b0, 4'hF, 32'h0000_0000, 32'h0);
      transfer(0, "r10_after", 1'b0, 4'hF, 32'h0000_0010, 32'h0);

      $display("[TB] zero wait states: back-to-back reads with req held");
      for (int i = 0; i < 8; i++)
         transfer(1, $sformatf("fill%0d", i), 1'b1, 4'hF, 32'h100 + 32'(4 * i), $urandom);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, $sformatf("b2b%0d", i), 1'b0, 4'hF, 32'h100 + 32'(4 * i), 32'h0);
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      req_a[1] = 1'b0;
      waitDone("b2b");
      transfer(1, "w_raw", 1'b1, 4'hF, 32'h104, 32'hCAFE_0104);
      applyStimulus(1, "r_raw", 1'b0, 4'hF, 32'h104, 32'h0);
      @(posedge clk); #1;
      req_a[1] = 1'b0;
      waitDone("r_raw");

      $display("[TB] three wait states: reset mid-transfer and protocol tolerance");
      transfer(2, "w40_old", 1'b1, 4'hF, 32'h0000_0040, 32'h5555_5555);
      req_a[2] = 1'b1; wr_a[2] = 1'b1; be_a[2] = 4'hF; addr_a[2] = 32'h40; din_a[2] = 32'hAAAA_AAAA;
      @(posedge clk); #1;
      req_a[2] = 1'b0;
      @(posedge clk); #1;
      rst_a[2] = 1'b0;
      @(posedge clk); #1;
      rst_a[2] = 1'b1;
      checkOutput("midrst_ack", {31'd0, ack_a[2]}, 32'd0);
      checkOutput("midrst_err", {31'd0, err_a[2]}, 32'd0);
      checkOutput("midrst_data", dout_a[2], 32'd0);
      repeat (8) @(posedge clk);
      #1;
      transfer(2, "r40_kept", 1'b0, 4'hF, 32'h0000_0040, 32'h0);
      applyStimulus(2, "r40_tol", 1'b0, 4'hF, 32'h0000_0040, 32'h0);
      @(posedge clk); #1;
      req_a[2] = 1'b0; addr_a[2] = 32'h0000_2000; wr_a[2] = 1'b1; be_a[2] = 4'h0; din_a[2] = 32'h1234_5678;
      waitDone("r40_tol");
      transfer(2, "r40_final", 1'b0, 4'hF, 32'h0000_0040, 32'h0);

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv32_mod_bus_responder_ram.md
# rv32_mod_bus_responder_ram

Word-organised RAM that is the responder end of the core's `req`/`ack`/`err` handshake bus, the same protocol the core's instruction and data ports drive as initiator. It decodes a single address window, applies byte-enabled writes, returns full-word reads, and completes each transfer with exactly one `ack` or `err` pulse after a programmable number of wait states. It is used as instruction memory, as data memory, and as the reference slave in core-level benches.

## Interface
- `DEPTH_WORDS`, 1024: storage depth in 32-bit words; power of two, at least 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_STATES`, 1: cycles spent in WAIT before the response; 0 to 15.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset; asserted when 0.
- `req`  in  1  transfer request from the initiator.
- `wr`  in  1  1 = write, 0 = read; qualified by `req`.
- `be`  in  4  byte enables; `be[i]` selects data bits `[8i+7:8i]`.
- `addr`  in  32  byte address; `addr[1:0]` is ignored.
- `data_i`  in  32  write data, already lane-aligned by the initiator.
- `ack`  out  1  one-cycle pulse: transfer completed successfully.
- `err`  out  1  one-cycle pulse: transfer rejected.
- `data_o`  out  32  read data; valid only while `ack` is high on a read.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE with `req`=1 samples the request. It latches `wr`, `be`, `data_i`, the word index `(addr-BASE_ADDR)>>2`, and `bad`.
  - `bad` = (`addr-BASE_ADDR` ≥ `DEPTH_WORDS*4`, unsigned 32-bit compare) OR (`be`==4'b0000).
- Next-state from IDLE on a sampled request:
  - WAIT_STATES>0: go to WAIT and load the wait counter with WAIT_STATES-1.
  - WAIT_STATES=0: go to RESP.
- WAIT decrements the counter each cycle and goes to RESP on the cycle the counter is 0.
- RESP lasts exactly one cycle, then returns to IDLE.
  - `bad`=1: `err`=1, `ack`=0, `data_o`=0, memory untouched.
  - `bad`=0, write: `ack`=1. At the closing edge, only the enabled byte lanes of the latched word are updated; the other lanes are preserved.
  - `bad`=0, read: `ack`=1 and `data_o` = the full stored word. `be` does not mask read data.
- `ack` and `err` are registered, mutually exclusive, and never high outside RESP.
- `data_o` is 0 whenever `ack` is not high on a read.
- The responder ignores inputs outside IDLE:
  - Changes to `req`, `addr`, `wr`, `be` or `data_i` during WAIT or RESP do not affect the transfer in flight.
  - A `req` dropped mid-transfer (a protocol violation) still receives its response.
- `req`=1 in the IDLE cycle immediately after RESP is a new transfer. Back-to-back transfers need no idle cycle.
- Reset (`reset`=0 at an edge):
  - FSM goes to IDLE, `ack`=`err`=0, `data_o`=0, wait counter cleared.
  - A pending write is discarded.
  - Memory contents are not cleared.

## Timing
- Request first high in cycle N (state IDLE) → response in cycle N+1+WAIT_STATES.
- Cycle occupancy per transfer is WAIT_STATES+2: one IDLE cycle, WAIT_STATES WAIT cycles, one RESP cycle.
- Read-after-write to the same word, back to back, returns the new data. The write commits at the RESP edge, before the next request's RESP.
- Reset values: `ack`=0, `err`=0, `data_o`=32'h0, state IDLE.
- No combinational path exists from any input to any output.

## Test plan
- Full write then read, WAIT_STATES=1, BASE_ADDR=0: write 32'hDEADBEEF to 0x10 with `be`=4'hF, then read 0x10 → each `ack` arrives 2 cycles after its `req`; read `data_o`=32'hDEADBEEF; `err` stays 0.
- Byte-lane write: word 0x20 holds 32'h11223344; write `be`=4'b0100 with `data_i`=32'h00AA0000, then read → `data_o`=32'h11AA3344.
- Error cases, DEPTH_WORDS=1024:
  - Read at 0x1000 → one `err` pulse, `ack`=0, `data_o`=0.
  - Write with `be`=0 → `err`.
  - Neither case modifies memory.
- WAIT_STATES=0 back to back: 8 consecutive reads with `req` held high → one `ack` every 2 cycles, each on the cycle after its request is sampled, with the correct data.
- Reset mid-transfer, WAIT_STATES=3: write issued, then `reset`=0 in the second WAIT cycle → no `ack` or `err` appears; a subsequent read of that word returns its pre-write value.
- Protocol tolerance: `req` dropped and `addr` changed during WAIT → the response still arrives on schedule for the originally latched address.
